// File: rtl/scandoubler_pkg.sv
// Shared types for the scandoubler video memory: FSM states, grant encoding, word width.
package scandoubler_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ      = 2'd2,
        ST_READ_DATA = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_VIDIN  = 1'b0,
        GRANT_VIDOUT = 1'b1
    } grant_e;

endpackage

// File: rtl/scandoubler_vidmem_ram.sv
// Single-port video RAM: registered address, read data valid one cycle after the address.
module scandoubler_vidmem_ram
    import scandoubler_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**AW];
    logic [AW-1:0]     addr_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        addr_q <= addr_i;
    end

    assign rdata_o = mem[addr_q];

endmodule

// File: rtl/scandoubler_vidmem.sv
// Toggle-handshake arbiter between the scandoubler write and read ports over one single-port RAM.
// Optional out-of-range suppression of accesses: define SCANDOUBLER_VIDMEM_BOUNDS_EN.
module scandoubler_vidmem
    import scandoubler_pkg::*;
#(
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter int FRAME_BITS = 1,
    parameter int H_MAX      = 256,
    parameter int V_MAX      = 128
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vidin_req,
    output logic              vidin_ack,
    input  logic [10:0]       vidin_x,
    input  logic [10:0]       vidin_y,
    input  logic [1:0]        vidin_frame,
    input  logic [DATA_W-1:0] vidin_d,
    input  logic              vidout_req,
    output logic              vidout_ack,
    input  logic [10:0]       vidout_x,
    input  logic [10:0]       vidout_y,
    input  logic [1:0]        vidout_frame,
    output logic [DATA_W-1:0] vidout_d,
    output logic              busy
);

    localparam int AW = FRAME_BITS + Y_BITS + X_BITS;
    localparam logic [10:0] H_LIM = 11'(H_MAX);
    localparam logic [10:0] V_LIM = 11'(V_MAX);

`ifdef SCANDOUBLER_VIDMEM_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    grant_e            last_q, last_d;
    logic              vin_ack_q, vin_ack_d;
    logic              vout_ack_q, vout_ack_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Access parameters captured at grant time; pure datapath, never reset.
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oob_q, oob_d;

    logic              in_pend, out_pend;
    logic              lat_en;
    grant_e            lat_sel;
    logic [AW-1:0]     in_addr, out_addr;
    logic              in_oob, out_oob;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_frame_bits;

    assign in_pend  = (vidin_req != vin_ack_q);
    assign out_pend = (vidout_req != vout_ack_q);

    // Upper coordinate bits are dropped here, so out-of-range accesses wrap unless bounds are enabled.
    assign in_addr  = {vidin_frame[FRAME_BITS-1:0], vidin_y[Y_BITS-1:0], vidin_x[X_BITS-1:0]};
    assign out_addr = {vidout_frame[FRAME_BITS-1:0], vidout_y[Y_BITS-1:0], vidout_x[X_BITS-1:0]};
    assign in_oob   = BOUNDS_EN && ((vidin_x >= H_LIM) || (vidin_y >= V_LIM));
    assign out_oob  = BOUNDS_EN && ((vidout_x >= H_LIM) || (vidout_y >= V_LIM));

    assign unused_frame_bits = ^{vidin_frame, vidout_frame};

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        vin_ack_d  = vin_ack_q;
        vout_ack_d = vout_ack_q;
        rd_data_d  = rd_data_q;
        lat_en     = 1'b0;
        lat_sel    = GRANT_VIDIN;

        case (state_q)
            ST_IDLE: begin
                // The tie-break memory only moves on contested grants, so consecutive ties alternate.
                if (out_pend && (!in_pend || (last_q != GRANT_VIDOUT))) begin
                    state_d = ST_READ;
                    lat_en  = 1'b1;
                    lat_sel = GRANT_VIDOUT;
                    if (in_pend) begin
                        last_d = GRANT_VIDOUT;
                    end
                end else if (in_pend) begin
                    state_d = ST_WRITE;
                    lat_en  = 1'b1;
                    lat_sel = GRANT_VIDIN;
                    if (out_pend) begin
                        last_d = GRANT_VIDIN;
                    end
                end
            end
            ST_WRITE: begin
                vin_ack_d = ~vin_ack_q;
                state_d   = ST_IDLE;
            end
            ST_READ: begin
                state_d = ST_READ_DATA;
            end
            ST_READ_DATA: begin
                rd_data_d  = oob_q ? '0 : ram_rdata;
                vout_ack_d = ~vout_ack_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        oob_d   = oob_q;
        if (lat_en) begin
            if (lat_sel == GRANT_VIDOUT) begin
                addr_d = out_addr;
                oob_d  = out_oob;
            end else begin
                addr_d  = in_addr;
                wdata_d = vidin_d;
                oob_d   = in_oob;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= GRANT_VIDIN;
            vin_ack_q  <= 1'b0;
            vout_ack_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            vin_ack_q  <= vin_ack_d;
            vout_ack_q <= vout_ack_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        oob_q   <= oob_d;
    end

    // The RAM registers addr_q every cycle; in READ it captures the read address for READ_DATA.
    assign ram_we = (state_q == ST_WRITE) && !oob_q;

    scandoubler_vidmem_ram #(
        .AW (AW)
    ) u_ram (
        .clk_i   (clk_sys),
        .we_i    (ram_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign vidin_ack  = vin_ack_q;
    assign vidout_ack = vout_ack_q;
    assign vidout_d   = rd_data_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/scandoubler_vidmem.md
SCANDOUBLER_VIDMEM -- requirements
Module: scandoubler_vidmem

Interface
REQ-001 SHALL have parameter X_BITS, default 8: column address bits.
REQ-002 SHALL have parameter Y_BITS, default 7: line address bits.
REQ-003 SHALL have parameter FRAME_BITS, default 1: frame-select bits, 1 or 2.
REQ-004 SHALL have parameter H_MAX, default 256, and V_MAX, default 128: valid extent, used for bounds checks only.
REQ-005 SHALL have port clk_sys, input, 1: the single clock; every port is synchronous to it.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports vidin_req in 1, vidin_ack out 1, vidin_x in 11, vidin_y in 11, vidin_frame in 2, vidin_d in 16: scandoubler write port.
REQ-008 SHALL have ports vidout_req in 1, vidout_ack out 1, vidout_x in 11, vidout_y in 11, vidout_frame in 2, vidout_d out 16: scandoubler read port.
REQ-009 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-010 SHALL treat each req as a level toggle: a port is pending while req != ack; completion is signalled by setting ack equal to req.
REQ-011 SHALL latch x, y, frame and d of the granted port in the cycle the grant is made; later input changes SHALL NOT affect that access.
REQ-012 SHALL form the word address as {frame[FRAME_BITS-1:0], y[Y_BITS-1:0], x[X_BITS-1:0]} into a single-port RAM of 2^(FRAME_BITS+Y_BITS+X_BITS) x 16.
REQ-013 SHALL implement the states IDLE, WRITE, READ, READ_DATA.
REQ-014 IDLE: if only vidin is pending -> WRITE; if only vidout is pending -> READ; if neither is pending -> stay in IDLE.
REQ-015 IDLE with both ports pending: SHALL grant vidout unless the previous grant was vidout, in which case SHALL grant vidin; ties therefore alternate.
REQ-016 WRITE: SHALL write the RAM, toggle vidin_ack on the same edge, and return to IDLE; the ack is visible 2 edges after the req toggle.
REQ-017 READ: SHALL present the RAM address and go to READ_DATA.
REQ-018 READ_DATA: SHALL register the RAM output into vidout_d, toggle vidout_ack on the same edge, and return to IDLE; the ack is visible 3 edges after the req toggle.
REQ-019 vidout_d SHALL hold its last value until the next read completes.
REQ-020 A req toggled again before its ack SHALL NOT be handled specially: it equals ack again and is therefore not pending; this is the initiator's protocol violation.
REQ-021 Sustained throughput SHALL be one write per 2 cycles and one read per 3 cycles, including the IDLE cycle.

Reset
REQ-022 Reset SHALL force IDLE, vidin_ack=0, vidout_ack=0, vidout_d=0, busy=0, and last-grant=vidin.
REQ-023 Reset asserted mid-access SHALL abort the access with no ack toggle; RAM contents are undefined afterwards and are not cleared.
REQ-024 Reset deassertion is synchronised externally; the first sampling SHALL occur on the first clk_sys edge after reset falls.

Configuration
REQ-025 With macro SCANDOUBLER_VIDMEM_BOUNDS_EN defined, an access with x >= H_MAX or y >= V_MAX SHALL be acked with normal timing, a write SHALL NOT modify the RAM, and a read SHALL return 16'h0000.
REQ-026 With SCANDOUBLER_VIDMEM_BOUNDS_EN undefined, x and y SHALL be truncated to X_BITS/Y_BITS and the access SHALL wrap with no bounds check.

Structure
REQ-027 The state enum, the grant encoding and the data width constant (16) SHALL live in the shared package scandoubler_pkg.
REQ-028 The RAM SHALL be a sub-module scandoubler_vidmem_ram: single-port, registered address, one-cycle read latency, inferable as block RAM.

Verification
REQ-029 Write then read: vidin_req 0->1 with x=5, y=3, frame=0, d=16'hABCD; after vidin_ack=1, vidout_req 0->1 with the same address -> vidout_ack=1 exactly 3 edges later and vidout_d=16'hABCD.
REQ-030 Simultaneous toggle of both reqs from reset -> vidout is served first (ack at +3), then vidin (ack at +5); a second simultaneous pair -> vidin is served first.
REQ-031 Frame isolation: write 16'h1111 at frame 0 and 16'h2222 at frame 1, same x/y -> reads return the respective values.
REQ-032 Bounds with the macro defined: write x=300, d=16'hFFFF -> acked; read x=300 -> 16'h0000; read x=44 (300 mod 256) -> previous contents unchanged.
REQ-033 Bounds with the macro undefined: the same write at x=300 -> a read at x=44 returns 16'hFFFF.
REQ-034 Reset pulsed during READ_DATA -> both acks are 0, vidout_d=0, busy=0; a fresh req after reset completes normally.
